control_unit: RTL
=================

Name: control_unit

Overview:
Fetch/execute sequencer that sits directly upstream of the 8-bit datapath and drives every control input of it: bus selects, register loads, PC increment/load, ALU operation select, output latch and RAM write strobe. It reads back the instruction register and flag register from the datapath. Program bytes come from ROM and data from RAM, both addressed by the datapath memory-access register with combinational read. One instruction executes at a time; there is no pipelining.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = an undefined opcode enters HALT; 0 = it executes as NOP. `illegalOp` is set in both cases.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
IROut  input  8  instruction register from datapath
flagRegisterOut  input  4  registered flags {N,Z,V,C} = bits [3:0]
bus1Select  output  2  00 PC, 01 A, 10 B
bus2Select  output  2  00 ALU, 01 bus1, 10 RAM, 11 ROM
IRLoad  output  1  load IR from bus2
memoryAccessRegisterLoad  output  1  load MAR from bus2
counterLoad  output  1  PC <= bus2
counterIncrement  output  1  PC <= MAR+1
counterIncrement2  output  1  tied 0
aLoad  output  1  A <= bus2
bLoad  output  1  B <= bus2
aluOperationSelect  output  3  equals IROut[2:0] at all times
flagRegisterLoad  output  1  capture ALU flags
outputLoad  output  2  00 none, 01 A, 10 B, 11 clear
ramWrite  output  1  RAM write strobe; data = bus1, address = MAR
instrDone  output  1  one-cycle pulse in an instruction's final cycle
halted  output  1  high while in HALT
illegalOp  output  1  sticky; set on an undefined opcode, cleared only by rst

Behaviour:
- State register: FETCH0, FETCH1, EXEC, OPER, DATA, HALT. All outputs are decoded from the registered state and IROut (Moore style). All outputs are 0 except in the states listed below. aluOperationSelect is a pass-through.
- rst=1 at a clock edge: state <= FETCH0, illegalOp <= 0. While rst=1, every control output is forced to 0. This applies mid-instruction and in HALT. The top level resets the datapath from the same source.
- FETCH0: bus1=00, bus2=01, memoryAccessRegisterLoad (MAR <= PC). Next state is FETCH1.
- FETCH1: bus2=11, IRLoad, counterIncrement. Next state is EXEC.
- Opcode is IROut[7:4]. The EXEC action and next state depend on the opcode:
  - 0x0 NOP: instrDone. Next FETCH0.
  - 0x1 LDA a / 0x2 LDB a / 0x3 STA a / 0x4 LIA i / 0x5 LIB i / 0x8 JMP a / 0x9 Jcc a: MAR <= PC (as in FETCH0). Next OPER.
  - 0x6 ALU: bus2=00, aLoad, flagRegisterLoad, instrDone. Next FETCH0.
  - 0x7 MOVAB: bus1=01, bus2=01, bLoad, instrDone. Next FETCH0.
  - 0xA OUT: outputLoad = IROut[0] ? 10 : 01, instrDone. Next FETCH0.
  - 0xB CLROUT: outputLoad=11, instrDone. Next FETCH0.
  - 0xF HALT: instrDone. Next HALT.
  - Other opcodes: set illegalOp, instrDone. Next HALT if HALT_ON_ILLEGAL=1, otherwise FETCH0.
- OPER (second byte on fromROM):
  - LDA/LDB/STA: bus2=11, memoryAccessRegisterLoad, counterIncrement. Next DATA.
  - LIA/LIB: bus2=11, aLoad/bLoad, counterIncrement, instrDone. Next FETCH0.
  - JMP: bus2=11, counterLoad, instrDone. Next FETCH0.
  - Jcc: the condition is flagRegisterOut[3 - IROut[1:0]] (00 N, 01 Z, 10 V, 11 C). IROut[2]=1 inverts the condition. Taken: bus2=11, counterLoad. Not taken: counterIncrement. Either way, instrDone and next FETCH0.
- DATA:
  - LDA/LDB: bus2=10, aLoad/bLoad.
  - STA: bus1=01, ramWrite.
  - All three: instrDone. Next FETCH0.
- HALT: holds, with halted=1 and all controls 0. Only rst exits HALT.
- Cycle counts: 1-byte instructions take 3 cycles; LIx/JMP/Jcc take 4; LDx/STA take 5.
- counterLoad and counterIncrement are never asserted together. ramWrite is never asserted with any register load.
- PC wraps 0xFF -> 0x00 through the datapath's 8-bit arithmetic; the control unit needs no special handling.

Test Plan:
1. ROM {0x40,0x05,0x50,0x03,0x60,0xA0,0xF0} -> 4,4,3,3,3 cycles per instruction; output register 0x08 when the ALU op is add; halted=1 after 17 cycles; instrDone pulsed 5 times.
2. RAM[0x20]=0x5A, ROM {0x10,0x20,0x30,0x21,0xF0} -> ramWrite high for exactly 1 cycle with address 0x21, toRAM 0x5A; RAM[0x21]=0x5A.
3. Flags Z=1, ROM {0x91,0x10,...}, then Z=0 with the same program -> PC=0x10 when taken, PC=0x02 when not taken; 0x95 inverts both outcomes.
4. Opcode 0xC0 with HALT_ON_ILLEGAL=0 -> illegalOp=1, next fetch from PC=0x01. With HALT_ON_ILLEGAL=1 -> halted=1, PC stays 0x01.
5. Assert rst during the DATA state of STA -> ramWrite=0 in that cycle; state restarts at FETCH0; illegalOp cleared.
6. JMP 0xFF, with ROM[0xFF]=0x00 (NOP) -> after the NOP, PC wraps to 0x00 and fetch resumes at address 0x00.

Source files
------------

// File: rtl/control_unit.sv
// Fetch/execute sequencer for the 8-bit datapath: Moore decode of the state and the IR, one instruction at a time.
// Latency: 3, 4 or 5 cycles per instruction. Backpressure: none; HALT holds until rst.
module control_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] IROut,
    input  logic [3:0] flagRegisterOut,
    output logic [1:0] bus1Select,
    output logic [1:0] bus2Select,
    output logic       IRLoad,
    output logic       memoryAccessRegisterLoad,
    output logic       counterLoad,
    output logic       counterIncrement,
    output logic       counterIncrement2,
    output logic       aLoad,
    output logic       bLoad,
    output logic [2:0] aluOperationSelect,
    output logic       flagRegisterLoad,
    output logic [1:0] outputLoad,
    output logic       ramWrite,
    output logic       instrDone,
    output logic       halted,
    output logic       illegalOp
);

    typedef enum logic [2:0] {FETCH0, FETCH1, EXEC, OPER, DATA, HALT} state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_LDB = 4'h2, OP_STA = 4'h3,
                           OP_LIA = 4'h4, OP_LIB = 4'h5, OP_ALU = 4'h6, OP_MOV = 4'h7,
                           OP_JMP = 4'h8, OP_JCC = 4'h9, OP_OUT = 4'hA, OP_CLR = 4'hB,
                           OP_HLT = 4'hF;

    state_t     state, state_nxt;
    logic       illegal_q;
    logic [3:0] opcode;
    logic       is_illegal;
    logic       jcc_taken;

    assign opcode             = IROut[7:4];
    assign is_illegal         = (opcode == 4'hC) || (opcode == 4'hD) || (opcode == 4'hE);
    // 3 - sel equals ~sel for a 2-bit selector: 00 N, 01 Z, 10 V, 11 C
    assign jcc_taken          = flagRegisterOut[~IROut[1:0]] ^ IROut[2];
    assign aluOperationSelect = IROut[2:0];
    assign counterIncrement2  = 1'b0;
    assign illegalOp          = illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == EXEC && is_illegal)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt                = state;
        bus1Select               = 2'b00;
        bus2Select               = 2'b00;
        IRLoad                   = 1'b0;
        memoryAccessRegisterLoad = 1'b0;
        counterLoad              = 1'b0;
        counterIncrement         = 1'b0;
        aLoad                    = 1'b0;
        bLoad                    = 1'b0;
        flagRegisterLoad         = 1'b0;
        outputLoad               = 2'b00;
        ramWrite                 = 1'b0;
        instrDone                = 1'b0;
        halted                   = 1'b0;
        case (state)
            FETCH0: begin
                bus2Select               = 2'b01;
                memoryAccessRegisterLoad = 1'b1;
                state_nxt                = FETCH1;
            end
            FETCH1: begin
                bus2Select       = 2'b11;
                IRLoad           = 1'b1;
                counterIncrement = 1'b1;
                state_nxt        = EXEC;
            end
            EXEC: begin
                instrDone = 1'b1;
                state_nxt = FETCH0;
                case (opcode)
                    OP_NOP: ;
                    OP_LDA, OP_LDB, OP_STA, OP_LIA, OP_LIB, OP_JMP, OP_JCC: begin
                        // operand byte sits at PC: point MAR at it
                        instrDone                = 1'b0;
                        bus2Select               = 2'b01;
                        memoryAccessRegisterLoad = 1'b1;
                        state_nxt                = OPER;
                    end
                    OP_ALU: begin
                        bus2Select       = 2'b00;
                        aLoad            = 1'b1;
                        flagRegisterLoad = 1'b1;
                    end
                    OP_MOV: begin
                        bus1Select = 2'b01;
                        bus2Select = 2'b01;
                        bLoad      = 1'b1;
                    end
                    OP_OUT:  outputLoad = IROut[0] ? 2'b10 : 2'b01;
                    OP_CLR:  outputLoad = 2'b11;
                    OP_HLT:  state_nxt = HALT;
                    default: state_nxt = HALT_ON_ILLEGAL ? HALT : FETCH0;
                endcase
            end
            OPER: begin
                state_nxt = FETCH0;
                case (opcode)
                    OP_LDA, OP_LDB, OP_STA: begin
                        bus2Select               = 2'b11;
                        memoryAccessRegisterLoad = 1'b1;
                        counterIncrement         = 1'b1;
                        state_nxt                = DATA;
                    end
                    OP_LIA, OP_LIB: begin
                        bus2Select       = 2'b11;
                        aLoad            = (opcode == OP_LIA);
                        bLoad            = (opcode == OP_LIB);
                        counterIncrement = 1'b1;
                        instrDone        = 1'b1;
                    end
                    OP_JMP: begin
                        bus2Select  = 2'b11;
                        counterLoad = 1'b1;
                        instrDone   = 1'b1;
                    end
                    OP_JCC: begin
                        bus2Select       = jcc_taken ? 2'b11 : 2'b00;
                        counterLoad      = jcc_taken;
                        counterIncrement = !jcc_taken;
                        instrDone        = 1'b1;
                    end
                    default: ;
                endcase
            end
            DATA: begin
                instrDone = 1'b1;
                state_nxt = FETCH0;
                case (opcode)
                    OP_LDA:  begin bus2Select = 2'b10; aLoad = 1'b1; end
                    OP_LDB:  begin bus2Select = 2'b10; bLoad = 1'b1; end
                    OP_STA:  begin bus1Select = 2'b01; ramWrite = 1'b1; end
                    default: ;
                endcase
            end
            HALT:    halted = 1'b1;
            default: state_nxt = FETCH0;
        endcase

        // reset silences the datapath immediately, even mid-instruction
        if (rst) begin
            bus1Select               = 2'b00;
            bus2Select               = 2'b00;
            IRLoad                   = 1'b0;
            memoryAccessRegisterLoad = 1'b0;
            counterLoad              = 1'b0;
            counterIncrement         = 1'b0;
            aLoad                    = 1'b0;
            bLoad                    = 1'b0;
            flagRegisterLoad         = 1'b0;
            outputLoad               = 2'b00;
            ramWrite                 = 1'b0;
            instrDone                = 1'b0;
            halted                   = 1'b0;
        end
    end

endmodule
